// File: rtl/sb_dmem_port_arbiter_pkg.sv
// sb_dmem_port_arbiter_pkg
//   Shared types for the data-cache port arbiter that splits the single
//   dcache port between the load pipeline and the store-buffer drain.
//   Contents:
//     dmem_arb_state_t : arbiter FSM state (IDLE, LD_WAIT, ST_WAIT)
//     ST_*             : 2-bit encodings of the same states, for checkers
package sb_dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } dmem_arb_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LD_WAIT = 2'd1;
  localparam logic [1:0] ST_ST_WAIT = 2'd2;

endpackage

// File: rtl/sb_dmem_port_arbiter.sv
// sb_dmem_port_arbiter
//   Shares the single dcache port between loads and the committed-store drain.
//   Each idle cycle it either forwards a load from the store buffer, issues
//   the store at the buffer head, or issues a load to the cache. At most one
//   cache request is outstanding. The store buffer is popped only when the
//   cache acknowledges the write.
//
//   Handshakes:
//     load      : a load is accepted in a cycle where ld_req && ld_ready.
//                 The result arrives later as a one-cycle ld_resp_valid pulse.
//     dcache    : a request is a one-cycle pulse on dmem_rmask/dmem_wmask
//                 (non-zero mask) with dmem_addr/dmem_wdata valid in that
//                 same cycle. dmem_resp is the completion of the single
//                 outstanding request. No new request is issued on the
//                 response cycle.
//     sb pop    : sb_dequeue pulses for one cycle, on the cache write response.
//
//   Ports:
//     clk, rst                : clock, synchronous active-high reset
//     flush                   : kills an in-flight load, never committed stores
//     sb_is_empty, sb_count   : store buffer status
//     sb_head_addr/wdata/wmask: store buffer head entry
//     sb_dequeue              : pop store buffer head
//     ld_req, ld_ready        : load request handshake
//     ld_addr, ld_rmask       : load address and byte mask
//     ld_sb_match, ld_fwd_data: store-buffer forwarding hit and data
//     ld_resp_valid, ld_rdata : load result
//     dmem_addr/rmask/wmask/wdata, dmem_resp, dmem_rdata : dcache port
//     arb_state               : current FSM state (debug)
module sb_dmem_port_arbiter
  import sb_dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned SB_DEPTH     = 32,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned HIGH_WM      = 24,
  parameter int unsigned LOW_WM       = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             sb_is_empty,
  input  logic [CNT_W-1:0] sb_count,
  input  logic [31:0]      sb_head_addr,
  input  logic [31:0]      sb_head_wdata,
  input  logic [3:0]       sb_head_wmask,
  output logic             sb_dequeue,
  input  logic             ld_req,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  input  logic             ld_sb_match,
  input  logic [31:0]      ld_fwd_data,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_rdata,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output dmem_arb_state_t  arb_state
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  // A high watermark above the buffer depth could never trigger.
  localparam int unsigned HIGH_EFF = (HIGH_WM < SB_DEPTH) ? HIGH_WM : SB_DEPTH;

  localparam logic [CNT_W-1:0] HIGH_TH = CNT_W'(HIGH_EFF);
  localparam logic [CNT_W-1:0] LOW_TH  = CNT_W'(LOW_WM);
  localparam logic [SW-1:0]    STARVE  = SW'(STARVE_LIMIT);

  dmem_arb_state_t state_q;
  logic            drain_q;
  logic [SW-1:0]   starve_q;
  logic            ld_killed_q;
  logic            fwd_valid_q;
  logic [31:0]     fwd_data_q;

  logic drain_eff;
  logic store_pri;
  logic take_fwd;
  logic take_st;
  logic take_ld;
  logic ld_done;

  always_comb begin
    // Hysteresis: the decision uses this cycle's occupancy, so drain starts
    // on the cycle sb_count reaches HIGH_WM and ends on the cycle it reaches
    // LOW_WM; in between the registered mode holds.
    drain_eff = drain_q;
    if (sb_count >= HIGH_TH) begin
      drain_eff = 1'b1;
    end else if (sb_count <= LOW_TH) begin
      drain_eff = 1'b0;
    end

    store_pri = !sb_is_empty && (drain_eff || (starve_q == STARVE) || !ld_req);
    ld_ready  = (state_q == IDLE) && !flush && (ld_sb_match || !store_pri);

    take_fwd = ld_req && ld_ready && ld_sb_match;
    take_st  = (state_q == IDLE) && !take_fwd && store_pri;
    take_ld  = ld_req && ld_ready && !ld_sb_match;

    ld_done = (state_q == LD_WAIT) && dmem_resp;

    // Gated with rst so a response landing in the reset cycle is dropped.
    ld_resp_valid = !rst && !flush && ((ld_done && !ld_killed_q) || fwd_valid_q);
    ld_rdata      = ld_done ? dmem_rdata : fwd_data_q;
    sb_dequeue    = !rst && (state_q == ST_WAIT) && dmem_resp;

    arb_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      starve_q    <= '0;
      ld_killed_q <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      dmem_addr   <= '0;
      dmem_rmask  <= '0;
      dmem_wmask  <= '0;
      dmem_wdata  <= '0;
    end else begin
      drain_q     <= drain_eff;
      fwd_valid_q <= take_fwd;
      if (take_fwd) begin
        fwd_data_q <= ld_fwd_data;
      end

      // Request fields are single-cycle pulses; idle cycles show all zeros.
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;

      case (state_q)
        IDLE: begin
          if (take_fwd) begin
            // Served from the store buffer; no cache traffic.
          end else if (take_st) begin
            dmem_addr  <= sb_head_addr;
            dmem_wmask <= sb_head_wmask;
            dmem_wdata <= sb_head_wdata;
            starve_q   <= '0;
            state_q    <= ST_WAIT;
          end else if (take_ld) begin
            dmem_addr  <= ld_addr;
            dmem_rmask <= ld_rmask;
            state_q    <= LD_WAIT;
            if (sb_is_empty) begin
              starve_q <= '0;
            end else if (starve_q != STARVE) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (sb_is_empty) begin
            starve_q <= '0;
          end
        end
        LD_WAIT: begin
          // A flushed load still owns the port until the cache answers.
          if (dmem_resp) begin
            ld_killed_q <= 1'b0;
            state_q     <= IDLE;
          end else if (flush) begin
            ld_killed_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmem_resp) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_dmem_port_arbiter.sv
// tb_sb_dmem_port_arbiter
//   Directed bench for sb_dmem_port_arbiter: a table of single-decision
//   vectors, then hand-written multi-cycle sequences (load latency, store
//   drain, starvation, watermarks, flush and reset corner cases).
module tb_sb_dmem_port_arbiter;
  import sb_dmem_port_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            flush;
  logic            sb_is_empty;
  logic [5:0]      sb_count;
  logic [31:0]     sb_head_addr;
  logic [31:0]     sb_head_wdata;
  logic [3:0]      sb_head_wmask;
  logic            sb_dequeue;
  logic            ld_req;
  logic            ld_ready;
  logic [31:0]     ld_addr;
  logic [3:0]      ld_rmask;
  logic            ld_sb_match;
  logic [31:0]     ld_fwd_data;
  logic            ld_resp_valid;
  logic [31:0]     ld_rdata;
  logic [31:0]     dmem_addr;
  logic [3:0]      dmem_rmask;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic            dmem_resp;
  logic [31:0]     dmem_rdata;
  dmem_arb_state_t arb_state;

  sb_dmem_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .sb_is_empty   (sb_is_empty),
    .sb_count      (sb_count),
    .sb_head_addr  (sb_head_addr),
    .sb_head_wdata (sb_head_wdata),
    .sb_head_wmask (sb_head_wmask),
    .sb_dequeue    (sb_dequeue),
    .ld_req        (ld_req),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_rmask      (ld_rmask),
    .ld_sb_match   (ld_sb_match),
    .ld_fwd_data   (ld_fwd_data),
    .ld_resp_valid (ld_resp_valid),
    .ld_rdata      (ld_rdata),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_resp     (dmem_resp),
    .dmem_rdata    (dmem_rdata),
    .arb_state     (arb_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush         = 1'b0;
    sb_is_empty   = 1'b1;
    sb_count      = 6'd0;
    sb_head_addr  = 32'h0000_0200;
    sb_head_wdata = 32'h1234_5678;
    sb_head_wmask = 4'h3;
    ld_req        = 1'b0;
    ld_addr       = 32'h0000_0100;
    ld_rmask      = 4'hF;
    ld_sb_match   = 1'b0;
    ld_fwd_data   = 32'hCAFE_0000;
    dmem_resp     = 1'b0;
    dmem_rdata    = 32'h0;
  endtask

  // Inputs change just after the falling edge; checks run 1 ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) nxt();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard for auto-responder runs ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         m_cnt;
  int         resp_delay;
  int         n_resp;
  int         first_ld_cnt;

  // Each cycle: model the store buffer occupancy, answer every cache request
  // two cycles after it appears, and log grants ('L' load, 'S' store).
  task automatic run_auto(input int n);
    for (int c = 0; c < n; c++) begin
      nxt();
      dmem_resp  = (resp_delay == 1);
      dmem_rdata = 32'h5A00_0000 | 32'(c);
      if (resp_delay > 0) resp_delay--;
      sb_count    = 6'(m_cnt);
      sb_is_empty = (m_cnt == 0);
      #1;
      if (dmem_wmask != 4'h0) begin
        obs_q.push_back("S");
        resp_delay = 2;
        check("st_addr", dmem_addr, 32'h0000_0200);
        check("st_wdata", dmem_wdata, 32'h1234_5678);
        check("st_rmask", {28'h0, dmem_rmask}, 32'h0);
      end
      if (dmem_rmask != 4'h0) begin
        obs_q.push_back("L");
        resp_delay = 2;
        if (first_ld_cnt < 0) first_ld_cnt = int'(sb_count);
        check("ld_addr", dmem_addr, 32'h0000_0100);
        check("ld_wmask", {28'h0, dmem_wmask}, 32'h0);
      end
      if (sb_dequeue) m_cnt--;
      if (ld_resp_valid) begin
        n_resp++;
        check("ld_rdata_auto", ld_rdata, dmem_rdata);
      end
    end
  endtask

  task automatic start_auto(input int cnt, input logic req);
    exp_q.delete();
    obs_q.delete();
    m_cnt        = cnt;
    resp_delay   = 0;
    n_resp       = 0;
    first_ld_cnt = -1;
    sb_count     = 6'(cnt);
    sb_is_empty  = (cnt == 0);
    ld_req       = req;
  endtask

  task automatic compare_grants(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check(tag, {24'h0, obs_q[i]}, {24'h0, exp_q[i]});
      else check({tag, "_missing"}, 32'h0, {24'h0, exp_q[i]});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld_req;
    logic       match;
    logic       empty;
    logic       flush;
    int         pre_cnt;
    int         cnt;
    logic       exp_ready;
    logic [3:0] exp_rmask;
    logic [3:0] exp_wmask;
    logic       exp_fwd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0,  0,  0, 1'b1, 4'hF, 4'h0, 1'b0}; // load, sb empty
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0,  2, 1'b1, 4'h0, 4'h0, 1'b1}; // forward
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,  0,  2, 1'b0, 4'h0, 4'h3, 1'b0}; // store, no load
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0,  7, 1'b1, 4'hF, 4'h0, 1'b0}; // load preferred
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 23, 1'b1, 4'hF, 4'h0, 1'b0}; // load preferred
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 24, 1'b0, 4'h0, 4'h3, 1'b0}; // high wm
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24, 23, 1'b0, 4'h0, 4'h3, 1'b0}; // drain holds
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24,  8, 1'b1, 4'hF, 4'h0, 1'b0}; // low wm exit
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24, 24, 1'b1, 4'h0, 4'h0, 1'b1}; // fwd beats drain
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1,  0,  0, 1'b0, 4'h0, 4'h0, 1'b0}; // flush blocks load
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 1'b0, 4'h0, 4'h0, 1'b0}; // flush blocks fwd
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1,  0,  2, 1'b0, 4'h0, 4'h3, 1'b0}; // flush keeps store
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0,  0,  0, 1'b1, 4'h0, 4'h0, 1'b0}; // nothing to do

    // ---- reset state ----
    rst = 1'b1;
    idle_inputs();
    repeat (2) nxt();
    #1;
    check("rst_state", {30'h0, arb_state}, {30'h0, ST_IDLE});
    check("rst_rmask", {28'h0, dmem_rmask}, 32'h0);
    check("rst_wmask", {28'h0, dmem_wmask}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_resp_valid", {31'h0, ld_resp_valid}, 32'h0);
    check("rst_rdata", ld_rdata, 32'h0);
    check("rst_dequeue", {31'h0, sb_dequeue}, 32'h0);

    // ---- table vectors: one idle-cycle decision each ----
    for (int i = 0; i < 13; i++) begin
      logic [31:0] exp_addr;
      exp_addr = (vecs[i].exp_rmask != 4'h0) ? 32'h100 :
                 (vecs[i].exp_wmask != 4'h0) ? 32'h200 : 32'h0;
      do_reset();
      sb_count = 6'(vecs[i].pre_cnt);
      nxt();
      ld_req      = vecs[i].ld_req;
      ld_sb_match = vecs[i].match;
      sb_is_empty = vecs[i].empty;
      flush       = vecs[i].flush;
      sb_count    = 6'(vecs[i].cnt);
      #1;
      check($sformatf("v%0d_ready", i), {31'h0, ld_ready}, {31'h0, vecs[i].exp_ready});
      nxt();
      ld_req = 1'b0; ld_sb_match = 1'b0; flush = 1'b0;
      sb_is_empty = 1'b1; sb_count = 6'd0;
      #1;
      check($sformatf("v%0d_rmask", i), {28'h0, dmem_rmask}, {28'h0, vecs[i].exp_rmask});
      check($sformatf("v%0d_wmask", i), {28'h0, dmem_wmask}, {28'h0, vecs[i].exp_wmask});
      check($sformatf("v%0d_addr", i), dmem_addr, exp_addr);
      check($sformatf("v%0d_fwd", i), {31'h0, ld_resp_valid}, {31'h0, vecs[i].exp_fwd});
      if (vecs[i].exp_fwd) check($sformatf("v%0d_fwd_data", i), ld_rdata, 32'hCAFE_0000);
      if ((vecs[i].exp_rmask | vecs[i].exp_wmask) != 4'h0) begin
        nxt();
        dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        #1;
        check($sformatf("v%0d_dequeue", i), {31'h0, sb_dequeue}, {31'h0, (vecs[i].exp_wmask != 4'h0)});
        check($sformatf("v%0d_ld_resp", i), {31'h0, ld_resp_valid}, {31'h0, (vecs[i].exp_rmask != 4'h0)});
        nxt();
        dmem_resp = 1'b0;
      end
    end

    // ---- load only, 3-cycle cache latency ----
    do_reset();
    ld_req = 1'b1;
    #1; check("ld3_ready", {31'h0, ld_ready}, 32'h1);
    nxt(); ld_req = 1'b0;
    #1; check("ld3_rmask", {28'h0, dmem_rmask}, 32'hF);
    nxt();
    #1; check("ld3_rmask_drop", {28'h0, dmem_rmask}, 32'h0);
    nxt(); dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld3_resp_valid", {31'h0, ld_resp_valid}, 32'h1);
    check("ld3_rdata", ld_rdata, 32'hDEAD_BEEF);
    check("ld3_no_dequeue", {31'h0, sb_dequeue}, 32'h0);
    nxt(); dmem_resp = 1'b0;
    #1;
    check("ld3_resp_once", {31'h0, ld_resp_valid}, 32'h0);
    check("ld3_idle", {30'h0, arb_state}, {30'h0, ST_IDLE});

    // ---- store drain of two entries ----
    do_reset();
    start_auto(2, 1'b0);
    exp_q.push_back("S"); exp_q.push_back("S");
    run_auto(16);
    compare_grants("drain_order");
    check("drain_grants", obs_q.size(), 32'd2);
    check("drain_pops", m_cnt, 32'd0);

    // ---- starvation: 8 loads, one store, loads resume ----
    do_reset();
    start_auto(3, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back("L");
    exp_q.push_back("S"); exp_q.push_back("L");
    run_auto(48);
    compare_grants("starve_order");
    check("starve_pops", m_cnt, 32'd2);
    check("starve_ld_resps", n_resp, 32'd11);

    // ---- watermark: stores from 24 until 8, then loads ----
    do_reset();
    start_auto(24, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back("S");
    exp_q.push_back("L"); exp_q.push_back("L");
    run_auto(80);
    compare_grants("wm_order");
    check("wm_first_load_cnt", first_ld_cnt, 32'd8);
    check("wm_final_cnt", m_cnt, 32'd8);

    // ---- flush while a load is outstanding ----
    do_reset();
    ld_req = 1'b1;
    nxt(); ld_req = 1'b0;
    #1; check("fl_ld_issue", {28'h0, dmem_rmask}, 32'hF);
    flush = 1'b1;
    nxt(); flush = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    #1; check("fl_ld_killed", {31'h0, ld_resp_valid}, 32'h0);
    nxt(); dmem_resp = 1'b0; ld_req = 1'b1;
    #1; check("fl_ld_ready_after", {31'h0, ld_ready}, 32'h1);
    nxt(); ld_req = 1'b0;
    nxt(); dmem_resp = 1'b1; dmem_rdata = 32'h2222_2222;
    #1;
    check("fl_ld_next_valid", {31'h0, ld_resp_valid}, 32'h1);
    check("fl_ld_next_data", ld_rdata, 32'h2222_2222);
    nxt(); dmem_resp = 1'b0;

    // ---- flush on the cycle a forward response is due ----
    do_reset();
    ld_req = 1'b1; ld_sb_match = 1'b1;
    nxt(); ld_req = 1'b0; ld_sb_match = 1'b0; flush = 1'b1;
    #1; check("fl_fwd_suppressed", {31'h0, ld_resp_valid}, 32'h0);
    nxt(); flush = 1'b0;

    // ---- flush while a store is outstanding ----
    do_reset();
    sb_count = 6'd1; sb_is_empty = 1'b0;
    nxt(); sb_count = 6'd0; sb_is_empty = 1'b1;
    #1; check("fl_st_issue", {28'h0, dmem_wmask}, 32'h3);
    flush = 1'b1;
    nxt(); dmem_resp = 1'b1;
    #1; check("fl_st_dequeue", {31'h0, sb_dequeue}, 32'h1);
    nxt(); dmem_resp = 1'b0; flush = 1'b0;

    // ---- reset while a store is outstanding ----
    do_reset();
    sb_count = 6'd1; sb_is_empty = 1'b0;
    nxt(); sb_count = 6'd0; sb_is_empty = 1'b1;
    #1; check("rst_st_issue", {28'h0, dmem_wmask}, 32'h3);
    rst = 1'b1;
    nxt(); rst = 1'b0; dmem_resp = 1'b1;
    #1;
    check("rst_st_no_dequeue", {31'h0, sb_dequeue}, 32'h0);
    check("rst_st_idle", {30'h0, arb_state}, {30'h0, ST_IDLE});
    check("rst_st_no_resp", {31'h0, ld_resp_valid}, 32'h0);
    nxt(); dmem_resp = 1'b0;

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
